// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and counter sizing.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    // Bit-period counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n_cycles);
        return (n_cycles > 2) ? $clog2(n_cycles) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready output, framing-error and overrun pulses.
// Optional UART_RX_MAJORITY_EN: each bit sample is a 3-sample majority vote.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned N_CYCLES = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    input  logic                      ready,
    output logic                      frame_error,
    output logic                      overrun
);

    localparam int unsigned DW = UART_DATA_BITS;
    localparam int unsigned CW = cnt_width(N_CYCLES);
    localparam int unsigned IW = $clog2(DW);
    localparam logic [CW-1:0] HALF_LOAD = CW'((N_CYCLES - 1) / 2);
    localparam logic [CW-1:0] FULL_LOAD = CW'(N_CYCLES - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DW - 1);

    logic          srx;
    uart_state_e   state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] bit_idx;
    logic [DW-1:0] shreg;
    logic          active_c;
    logic          tick_c;
    logic          sample_c;
    logic          byte_done_c;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clock),
        .rst_n (reset),
        .d     (rx),
        .q     (srx)
    );

`ifdef UART_RX_MAJORITY_EN
    // Two previous srx values; with the current srx they form the voting window.
    logic [1:0] hist;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist <= '1;
        end else begin
            hist <= {hist[0], srx};
        end
    end

    assign sample_c = (srx & hist[0]) | (srx & hist[1]) | (hist[0] & hist[1]);
`else
    assign sample_c = srx;
`endif

    assign active_c    = (state == START) || (state == DATA) || (state == STOP);
    assign tick_c      = active_c && (cnt == '0);
    assign byte_done_c = (state == STOP) && tick_c && sample_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            data        <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;

            if (tick_c) begin
                cnt <= FULL_LOAD;
            end else if (active_c) begin
                cnt <= cnt - CW'(1);
            end

            case (state)
                IDLE: begin
                    // First sample lands mid start bit.
                    if (!srx) begin
                        state <= START;
                        cnt   <= HALF_LOAD;
                    end
                end
                START: begin
                    if (tick_c) begin
                        if (sample_c) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (tick_c) begin
                        shreg   <= {sample_c, shreg[DW-1:1]};
                        bit_idx <= bit_idx + IW'(1);
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    // Leave mid stop bit so an immediately following start edge is caught.
                    if (tick_c) begin
                        if (sample_c) begin
                            state <= IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (srx) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Output holding register: a new byte may replace one being consumed this cycle.
            if (byte_done_c) begin
                if (!valid || ready) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: fixed frame table, corner sequences and random frames.
module tb_uart_rx;

    localparam int unsigned N = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_error;
    logic       overrun;

    uart_rx #(.N_CYCLES(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int         checks    = 0;
    int         errors    = 0;
    logic [7:0] got_q[$];
    int         ferr_cnt  = 0;
    int         ovr_cnt   = 0;
    int         rise_cyc  = -1;
    int         ovr_cyc   = -1;
    int         start_cyc = 0;
    logic       valid_prev = 1'b0;
    int         b0, f0, o0;

    // Observe outputs mid-cycle: handshakes, pulse counts and event times.
    always @(negedge clock) begin
        if (valid === 1'b1 && ready === 1'b1) got_q.push_back(data);
        if (frame_error === 1'b1) ferr_cnt++;
        if (overrun === 1'b1) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (valid === 1'b1 && valid_prev !== 1'b1) rise_cyc = cyc;
        valid_prev = valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] last_byte();
        if (got_q.size() == 0) return 'x;
        return got_q[got_q.size()-1];
    endfunction

    task automatic snapshot();
        b0 = got_q.size();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (N) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

`ifdef UART_RX_MAJORITY_EN
    // One-cycle inverted glitch placed where a single-sample receiver would look.
    task automatic send_frame_glitch(input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            rx = bits[j];
            repeat (8) @(posedge clock);
            #1;
            rx = ~bits[j];
            @(posedge clock);
            #1;
            rx = bits[j];
            repeat (7) @(posedge clock);
            #1;
        end
    endtask
`endif

    typedef struct {
        logic [7:0] byt;
        logic       stop;
        int         gap;
        int         exp_beats;
        int         exp_ferr;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] exp_q[$];
    int         exp_fe;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h00, 1'b1, 0, 1, 0};
        vecs[1] = '{8'hFF, 1'b1, 0, 1, 0};
        vecs[2] = '{8'h3C, 1'b1, 0, 1, 0};
        vecs[3] = '{8'h5A, 1'b1, 3, 1, 0};
        vecs[4] = '{8'h81, 1'b0, 6, 0, 1};
        vecs[5] = '{8'h01, 1'b1, 0, 1, 0};
        vecs[6] = '{8'h80, 1'b1, 2, 1, 0};
        vecs[7] = '{8'hC3, 1'b0, 4, 0, 1};

        repeat (3) @(posedge clock);
        #1;
        check("reset_valid", valid, 0);
        check("reset_data", data, 0);
        check("reset_ferr", frame_error, 0);
        check("reset_ovr", overrun, 0);
        reset = 1'b1;
        ready = 1'b1;
        idle(10);

        // Single frame with exact latency from the rx falling edge.
        snapshot();
        rise_cyc = -1;
        send_frame(8'hA5, 1'b1);
        check("a5_latency", rise_cyc - start_cyc, 155);
        check("a5_beats", got_q.size() - b0, 1);
        check("a5_data", last_byte(), 8'hA5);
        check("a5_ferr", ferr_cnt - f0, 0);
        check("a5_ovr", ovr_cnt - o0, 0);

        // Frame table, gap 0 means full line rate.
        for (int v = 0; v < 8; v++) begin
            snapshot();
            send_frame(vecs[v].byt, vecs[v].stop);
            idle(vecs[v].gap);
            check($sformatf("vec%0d_beats", v), got_q.size() - b0, vecs[v].exp_beats);
            if (vecs[v].exp_beats == 1) check($sformatf("vec%0d_data", v), last_byte(), vecs[v].byt);
            check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_ovr", v), ovr_cnt - o0, 0);
        end

        // Overrun: second byte dropped while first is unconsumed.
        ready = 1'b0;
        idle(4);
        snapshot();
        ovr_cyc = -1;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("ovr_count", ovr_cnt - o0, 1);
        check("ovr_time", ovr_cyc - start_cyc, 155);
        check("ovr_valid_held", valid, 1);
        check("ovr_data_held", data, 8'h11);
        check("ovr_no_beats", got_q.size() - b0, 0);
        ready = 1'b1;
        @(posedge clock);
        #1;
        check("ovr_accept_beats", got_q.size() - b0, 1);
        check("ovr_accept_data", last_byte(), 8'h11);
        check("ovr_valid_drop", valid, 0);

        // Short low glitch is a false start.
        idle(4);
        snapshot();
        rx = 1'b0;
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        idle(30);
        check("glitch_beats", got_q.size() - b0, 0);
        check("glitch_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        send_frame(8'h5A, 1'b1);
        idle(2);
        check("glitch_next_beats", got_q.size() - b0, 1);
        check("glitch_next_data", last_byte(), 8'h5A);

        // Bad stop bit followed by a long break, then a good frame.
        snapshot();
        send_frame(8'h81, 1'b0);
        rx = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
        end
        idle(4);
        send_frame(8'h7E, 1'b1);
        idle(2);
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_beats", got_q.size() - b0, 1);
        check("break_data", last_byte(), 8'h7E);
        check("break_ovr", ovr_cnt - o0, 0);

        // Reset in the middle of a frame with a byte still pending.
        ready = 1'b0;
        send_frame(8'h3C, 1'b1);
        idle(2);
        check("rst_pre_valid", valid, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b0;
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        #1;
        check("rst_mid_valid", valid, 0);
        check("rst_mid_data", data, 0);
        rx = 1'b1;
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        check("rst_hold_valid", valid, 0);
        check("rst_hold_flags", {frame_error, overrun}, 0);
        reset = 1'b1;
        ready = 1'b1;
        idle(20);
        snapshot();
        send_frame(8'h96, 1'b1);
        idle(2);
        check("rst_after_beats", got_q.size() - b0, 1);
        check("rst_after_data", last_byte(), 8'h96);
        check("rst_after_ferr", ferr_cnt - f0, 0);

`ifdef UART_RX_MAJORITY_EN
        snapshot();
        send_frame_glitch(8'h55);
        idle(2);
        check("maj_beats", got_q.size() - b0, 1);
        check("maj_data", last_byte(), 8'h55);
        check("maj_ferr", ferr_cnt - f0, 0);
`endif

        // Random frames: model is simply the list of well-stopped bytes in order.
        snapshot();
        exp_q.delete();
        exp_fe = 0;
        for (int k = 0; k < 16; k++) begin
            logic [7:0] byt;
            logic       bad;
            int         gap;
            byt = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            gap = bad ? int'($urandom_range(2, 12)) : int'($urandom_range(0, 12));
            send_frame(byt, ~bad);
            idle(gap);
            if (bad) exp_fe++;
            else exp_q.push_back(byt);
        end
        idle(5);
        check("rand_beats", got_q.size() - b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (b0 + i < got_q.size()) check($sformatf("rand_data%0d", i), got_q[b0+i], exp_q[i]);
        end
        check("rand_ferr", ferr_cnt - f0, exp_fe);
        check("rand_ovr", ovr_cnt - o0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side counterpart of the UART transmitter: 8N1 asynchronous serial in, byte stream out.
- Frame format, LSB-first ordering and the bit-period parameter match the transmitter, so a TX→RX loopback is bit-exact.
- Sits between the board RX pin and the CPU/bus-side consumer.
- Presents bytes on a valid/ready handshake and flags framing errors and overruns.

Parameters:
- N_CYCLES, 16, clock cycles per bit period; must be ≥ 4.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- rx  in  1  raw serial line, idle high, asynchronous to clock.
- data  out  8  received byte; stable while valid=1.
- valid  out  1  byte available; held until accepted.
- ready  in  1  consumer accepts data when valid & ready.
- frame_error  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: completed byte dropped because the output register was full.

Behaviour:
- Reset values (reset=0, asynchronous): valid=0, data=0, frame_error=0, overrun=0, FSM=IDLE, synchroniser flops=1, counter=0.
- Synchroniser:
  - rx passes through 2 flops; "srx" is the second flop.
  - All decisions use srx, giving 2 cycles of input latency.
- Counter:
  - Width $clog2(N_CYCLES); down-counter.
  - "Tick" = counter==0 while in an active state. On a tick the counter reloads N_CYCLES-1.
- FSM states:
  - IDLE: srx==0 → START, load counter with (N_CYCLES-1)/2 (integer division).
  - START: on tick, sample srx.
    - sample==1 → IDLE (glitch / false start; no flags raised).
    - sample==0 → DATA, bit index=0.
  - DATA: on tick, shift the sample into the MSB of an 8-bit shift register (shift right), bit index+1. After the 8th sample → STOP.
  - STOP: on tick, sample srx.
    - 1 → byte complete, go to IDLE.
    - 0 → frame_error=1 for that one cycle, byte discarded, go to BREAK.
  - BREAK: wait for srx==1, then IDLE; no start detection in this state.
- STOP→IDLE occurs at mid-stop-bit, so a start bit immediately following the stop bit is detected. Back-to-back frames at full line rate must be received with no loss.
- Output register, on byte complete:
  - valid==0 → data=shift register, valid=1 on the next cycle.
  - valid==1 & ready==1 in the same cycle → old byte consumed, new byte loaded, valid stays 1, no overrun.
  - valid==1 & ready==0 → new byte dropped, data/valid unchanged, overrun=1 for one cycle.
- valid & ready with no byte completing → valid=0 on the next cycle; data is don't-care afterwards but is held.
- ready is ignored while valid=0.
- Latency, with D = first cycle srx==0 in IDLE:
  - start sample at D+(N_CYCLES-1)/2+1;
  - stop sample 9·N_CYCLES cycles later;
  - valid rises the cycle after the stop sample.
- Reset asserted mid-frame: immediate return to reset values, partial byte lost. After release, the next rx falling edge starts a new frame. A frame already in progress at release is received as garbage or raises frame_error; no lock-up.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined:
  - 3-bit history of srx; each START/DATA/STOP sample = majority of the last 3 srx values at the tick.
  - Timing is identical; IDLE start detection still uses srx directly.
  - Requires N_CYCLES ≥ 6.
- Undefined: single-sample srx at the tick; the history register is absent.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, BREAK);
  - UART_DATA_BITS=8;
  - helper function for the counter width from N_CYCLES.
- Natural sub-module: sync_2ff, a generic 2-flop synchroniser with a reset value parameter (1 here), reusable for other async inputs.

Test Plan (N_CYCLES=16):
- Drive 0xA5 frame, ready=1 → one valid cycle with data=0xA5, no flags; valid rises 2+8+144+1=155 cycles after the rx falling edge.
- 0x00, 0xFF, 0x3C back-to-back at full rate, ready=1 → three valid beats in order, no frame_error/overrun.
- Send 0x11 then 0x22 with ready=0 throughout → data=0x11 held, overrun pulses once at the second stop sample. Then ready=1 → 0x11 accepted, valid drops.
- rx low pulse of 4 cycles then high → returns to IDLE, no valid/flags. Following 0x5A frame is received correctly.
- 0x81 frame with stop bit forced 0, rx held low 40 cycles, then 0x7E → frame_error pulse, no valid for the bad byte, 0x7E received.
- Reset asserted mid-DATA of 0xC3, released, then 0x96 → outputs at reset values during reset, 0x96 received.
- UART_RX_MAJORITY_EN build: single-cycle inverted glitch at each mid-bit of 0x55 → still 0x55.
